// File: rtl/br_stat_collector.sv
// Branch-predictor statistics: saturating branch/miss/orphan/fetch counters plus an
// optional miss-PC log FIFO, built only when the macro BR_STAT_LOG_EN is defined.
module br_stat_collector #(
    parameter int CNT_WIDTH = 32,
    parameter int LOG_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 br_instr_i,
    input  logic                 br_miss_i,
    input  logic [31:0]          instr_i,
    input  logic [31:0]          pc_i,
    output logic [CNT_WIDTH-1:0] br_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o,
    output logic [CNT_WIDTH-1:0] orphan_cnt_o,
    output logic [CNT_WIDTH-1:0] instr_cnt_o,
    output logic [31:0]          log_pc_o,
    output logic                 log_valid_o,
    input  logic                 log_ready_i,
    output logic                 log_ovf_o
);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (&value) ? value : value + CNT_WIDTH'(1);
    endfunction

    logic qual_miss;
    logic is_bubble;

    assign qual_miss = en_i & br_instr_i & br_miss_i;
    assign is_bubble = (instr_i == 32'h0000_0013) || (instr_i == 32'h0000_0000);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            br_cnt_o     <= '0;
            miss_cnt_o   <= '0;
            orphan_cnt_o <= '0;
            instr_cnt_o  <= '0;
        end else if (en_i) begin
            if (br_instr_i) begin
                br_cnt_o <= sat_inc(br_cnt_o);
            end
            if (br_instr_i && br_miss_i) begin
                miss_cnt_o <= sat_inc(miss_cnt_o);
            end
            if (!br_instr_i && br_miss_i) begin
                orphan_cnt_o <= sat_inc(orphan_cnt_o);
            end
            if (!is_bubble) begin
                instr_cnt_o <= sat_inc(instr_cnt_o);
            end
        end
    end

`ifdef BR_STAT_LOG_EN
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(LOG_DEPTH);

    logic [31:0]      mem [LOG_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;

    // A pop in the same cycle frees the slot, so a full log still accepts the push.
    assign empty  = (count == '0);
    assign full   = (count == FULL_COUNT);
    assign pop    = !empty && log_ready_i;
    assign accept = qual_miss && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            log_ovf_o <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !accept) begin
                count <= count - (PTR_W + 1)'(1);
            end
            if (qual_miss && !accept) begin
                log_ovf_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && !rst_i && !clear_i) begin
            mem[wr_ptr] <= pc_i;
        end
    end

    assign log_valid_o = !empty;
    assign log_pc_o    = empty ? 32'h0000_0000 : mem[rd_ptr];
`else
    logic unused_log;

    assign unused_log  = ^{log_ready_i, pc_i, qual_miss, (LOG_DEPTH > 1)};
    assign log_valid_o = 1'b0;
    assign log_pc_o    = 32'h0000_0000;
    assign log_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_br_stat_collector.sv
// Self-checking bench for br_stat_collector: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model; expectations follow BR_STAT_LOG_EN.
module tb_br_stat_collector;

    localparam int LOG_DEPTH = 8;
`ifdef BR_STAT_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        en;
    logic        br_instr;
    logic        br_miss;
    logic        log_ready;
    logic [31:0] instr;
    logic [31:0] pc;

    logic [31:0] br_cnt, miss_cnt, orphan_cnt, instr_cnt, log_pc;
    logic        log_valid, log_ovf;
    logic [3:0]  br_cnt4, miss_cnt4, orphan_cnt4, instr_cnt4;
    logic [31:0] log_pc4;
    logic        log_valid4, log_ovf4;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_br, m_miss, m_orphan, m_instr;
    logic [31:0] m_q[$];
    bit          m_ovf;

    always #5 clk = ~clk;

    br_stat_collector #(.CNT_WIDTH(32), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .en_i(en),
        .br_instr_i(br_instr), .br_miss_i(br_miss), .instr_i(instr), .pc_i(pc),
        .br_cnt_o(br_cnt), .miss_cnt_o(miss_cnt), .orphan_cnt_o(orphan_cnt),
        .instr_cnt_o(instr_cnt), .log_pc_o(log_pc), .log_valid_o(log_valid),
        .log_ready_i(log_ready), .log_ovf_o(log_ovf)
    );

    br_stat_collector #(.CNT_WIDTH(4), .LOG_DEPTH(LOG_DEPTH)) dut4 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .en_i(en),
        .br_instr_i(br_instr), .br_miss_i(br_miss), .instr_i(instr), .pc_i(pc),
        .br_cnt_o(br_cnt4), .miss_cnt_o(miss_cnt4), .orphan_cnt_o(orphan_cnt4),
        .instr_cnt_o(instr_cnt4), .log_pc_o(log_pc4), .log_valid_o(log_valid4),
        .log_ready_i(log_ready), .log_ovf_o(log_ovf4)
    );

    task automatic apply_stimulus(input int r, input int c, input int e, input int b,
                                  input int m, input logic [31:0] i, input logic [31:0] p,
                                  input int rd);
        rst       = (r != 0);
        clear     = (c != 0);
        en        = (e != 0);
        br_instr  = (b != 0);
        br_miss   = (m != 0);
        instr     = i;
        pc        = p;
        log_ready = (rd != 0);
    endtask

    // Model written from the rules: saturating counts and a bounded queue of miss PCs.
    task automatic model_step();
        bit pop;
        bit push;
        if (rst || clear) begin
            m_br = 0; m_miss = 0; m_orphan = 0; m_instr = 0;
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        pop  = LOG_EN && (m_q.size() > 0) && log_ready;
        push = LOG_EN && en && br_instr && br_miss;
        if (en) begin
            if (br_instr && m_br != 32'hFFFF_FFFF) m_br++;
            if (br_instr && br_miss && m_miss != 32'hFFFF_FFFF) m_miss++;
            if (!br_instr && br_miss && m_orphan != 32'hFFFF_FFFF) m_orphan++;
            if (instr != 32'h13 && instr != 32'h0 && m_instr != 32'hFFFF_FFFF) m_instr++;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < LOG_DEPTH) m_q.push_back(pc);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        apply_stimulus(1, 1, 1, 1, 1, 32'h00A0_0093, 32'h40, 1);
        tick();
        checks++; if (br_cnt !== 0)     begin failures++; $display("[TB] FAIL reset_br: got %0h expected 0", br_cnt); end
        checks++; if (miss_cnt !== 0)   begin failures++; $display("[TB] FAIL reset_miss: got %0h expected 0", miss_cnt); end
        checks++; if (orphan_cnt !== 0) begin failures++; $display("[TB] FAIL reset_orphan: got %0h expected 0", orphan_cnt); end
        checks++; if (instr_cnt !== 0)  begin failures++; $display("[TB] FAIL reset_instr: got %0h expected 0", instr_cnt); end
        checks++; if (log_valid !== 1'b0 || log_pc !== 32'h0 || log_ovf !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_log: got valid=%b pc=%0h ovf=%b expected 0/0/0", log_valid, log_pc, log_ovf);
        end
    endtask

    task automatic test_branches();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, 1, 1, 0, 32'h0, 32'h0, 0);
            tick();
        end
        checks++; if (br_cnt !== 5)     begin failures++; $display("[TB] FAIL branches_br: got %0d expected 5", br_cnt); end
        checks++; if (miss_cnt !== 0)   begin failures++; $display("[TB] FAIL branches_miss: got %0d expected 0", miss_cnt); end
        checks++; if (log_valid !== 0)  begin failures++; $display("[TB] FAIL branches_valid: got %b expected 0", log_valid); end
    endtask

    task automatic test_log_order();
        logic [31:0] exp_pc;
        apply_stimulus(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 1, 1, 1, 32'h0, 32'h100 + 32'(4 * i), 0);
            tick();
        end
        checks++; if (miss_cnt !== 3) begin failures++; $display("[TB] FAIL order_miss: got %0d expected 3", miss_cnt); end
        // Drain with collection paused; pops must continue.
        apply_stimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            exp_pc = LOG_EN ? 32'h100 + 32'(4 * i) : 32'h0;
            checks++; if (log_pc !== exp_pc || log_valid !== LOG_EN) begin
                failures++; $display("[TB] FAIL order_head%0d: got pc=%0h valid=%b expected pc=%0h valid=%b", i, log_pc, log_valid, exp_pc, LOG_EN);
            end
            tick();
        end
        checks++; if (log_valid !== 1'b0 || log_pc !== 32'h0) begin
            failures++; $display("[TB] FAIL order_empty: got valid=%b pc=%0h expected 0/0", log_valid, log_pc);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc;
        apply_stimulus(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(0, 0, 1, 1, 1, 32'h0, 32'h200 + 32'(4 * i), 0);
            tick();
        end
        checks++; if (miss_cnt !== 9)  begin failures++; $display("[TB] FAIL ovf_miss: got %0d expected 9", miss_cnt); end
        checks++; if (log_ovf !== LOG_EN) begin failures++; $display("[TB] FAIL ovf_flag: got %b expected %b", log_ovf, LOG_EN); end
        apply_stimulus(0, 0, 1, 1, 1, 32'h0, 32'h300, 1);
        tick();
        checks++; if (miss_cnt !== 10) begin failures++; $display("[TB] FAIL ovf_miss10: got %0d expected 10", miss_cnt); end
        checks++; if (log_ovf !== LOG_EN) begin failures++; $display("[TB] FAIL ovf_sticky: got %b expected %b", log_ovf, LOG_EN); end
        apply_stimulus(0, 0, 1, 0, 0, 32'h0, 32'h0, 1);
        for (int k = 0; k < 8; k++) begin
            exp_pc = !LOG_EN ? 32'h0 : (k < 7 ? 32'h204 + 32'(4 * k) : 32'h300);
            checks++; if (log_pc !== exp_pc || log_valid !== LOG_EN) begin
                failures++; $display("[TB] FAIL ovf_drain%0d: got pc=%0h valid=%b expected pc=%0h valid=%b", k, log_pc, log_valid, exp_pc, LOG_EN);
            end
            tick();
        end
        checks++; if (log_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_empty: got %b expected 0", log_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        apply_stimulus(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        tick();
        apply_stimulus(0, 0, 1, 1, 1, 32'h0, 32'hA00, 0);
        tick();
        apply_stimulus(0, 0, 1, 1, 1, 32'h0, 32'hB00, 1);
        tick();
        exp_pc = LOG_EN ? 32'hB00 : 32'h0;
        checks++; if (log_pc !== exp_pc || log_valid !== LOG_EN) begin
            failures++; $display("[TB] FAIL b2b_head: got pc=%0h valid=%b expected pc=%0h valid=%b", log_pc, log_valid, exp_pc, LOG_EN);
        end
        apply_stimulus(0, 0, 1, 0, 0, 32'h0, 32'h0, 1);
        tick();
        checks++; if (log_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty: got %b expected 0", log_valid); end
    endtask

    task automatic test_orphan();
        apply_stimulus(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        tick();
        apply_stimulus(0, 0, 1, 0, 1, 32'h13, 32'h500, 0);
        tick();
        checks++; if (orphan_cnt !== 1) begin failures++; $display("[TB] FAIL orphan_cnt: got %0d expected 1", orphan_cnt); end
        checks++; if (miss_cnt !== 0)   begin failures++; $display("[TB] FAIL orphan_miss: got %0d expected 0", miss_cnt); end
        checks++; if (log_valid !== 0)  begin failures++; $display("[TB] FAIL orphan_log: got %b expected 0", log_valid); end
        checks++; if (instr_cnt !== 0)  begin failures++; $display("[TB] FAIL nop_instr: got %0d expected 0", instr_cnt); end
        apply_stimulus(0, 0, 1, 0, 0, 32'h00A0_0093, 32'h0, 0);
        tick();
        checks++; if (instr_cnt !== 1)  begin failures++; $display("[TB] FAIL real_instr: got %0d expected 1", instr_cnt); end
    endtask

    task automatic test_saturation();
        apply_stimulus(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(0, 0, 1, 1, 0, 32'h0, 32'h0, 0);
            tick();
        end
        checks++; if (br_cnt4 !== 4'd15) begin failures++; $display("[TB] FAIL sat_br4: got %0d expected 15", br_cnt4); end
        checks++; if (br_cnt !== 20)     begin failures++; $display("[TB] FAIL sat_br32: got %0d expected 20", br_cnt); end
        apply_stimulus(0, 1, 1, 1, 1, 32'h00A0_0093, 32'h600, 0);
        tick();
        checks++; if (br_cnt4 !== 4'd0 || br_cnt !== 0) begin
            failures++; $display("[TB] FAIL clear_prio: got br4=%0d br=%0d expected 0/0", br_cnt4, br_cnt);
        end
        checks++; if (log_valid !== 1'b0 || miss_cnt !== 0) begin
            failures++; $display("[TB] FAIL clear_log: got valid=%b miss=%0d expected 0/0", log_valid, miss_cnt);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 1, 1, 1, 32'h00A0_0093, 32'h700 + 32'(4 * i), 0);
            tick();
        end
        checks++; if (log_valid !== LOG_EN) begin failures++; $display("[TB] FAIL rdrain_pre: got %b expected %b", log_valid, LOG_EN); end
        apply_stimulus(1, 0, 1, 1, 1, 32'h00A0_0093, 32'h800, 1);
        tick();
        checks++; if (log_valid !== 1'b0 || log_pc !== 32'h0) begin
            failures++; $display("[TB] FAIL rdrain_log: got valid=%b pc=%0h expected 0/0", log_valid, log_pc);
        end
        checks++; if (br_cnt !== 0 || miss_cnt !== 0 || instr_cnt !== 0 || orphan_cnt !== 0) begin
            failures++; $display("[TB] FAIL rdrain_cnt: got %0d/%0d/%0d/%0d expected all 0", br_cnt, miss_cnt, instr_cnt, orphan_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] rand_instr;
        bit          exp_valid;
        int          sel;
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 2));
            rand_instr = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h13 : $urandom;
            apply_stimulus(int'($urandom_range(0, 79) == 0), int'($urandom_range(0, 59) == 0),
                           int'($urandom_range(0, 7) != 0), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 2) == 0), rand_instr,
                           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                           int'($urandom_range(0, 3) == 0));
            tick();
            exp_valid = (m_q.size() != 0);
            exp_pc    = exp_valid ? m_q[0] : 32'h0;
            checks++; if (br_cnt !== m_br)         begin failures++; $display("[TB] FAIL rand_br@%0d: got %0d expected %0d", n, br_cnt, m_br); end
            checks++; if (miss_cnt !== m_miss)     begin failures++; $display("[TB] FAIL rand_miss@%0d: got %0d expected %0d", n, miss_cnt, m_miss); end
            checks++; if (orphan_cnt !== m_orphan) begin failures++; $display("[TB] FAIL rand_orphan@%0d: got %0d expected %0d", n, orphan_cnt, m_orphan); end
            checks++; if (instr_cnt !== m_instr)   begin failures++; $display("[TB] FAIL rand_instr@%0d: got %0d expected %0d", n, instr_cnt, m_instr); end
            checks++; if (log_valid !== exp_valid || log_pc !== exp_pc) begin
                failures++; $display("[TB] FAIL rand_head@%0d: got valid=%b pc=%0h expected valid=%b pc=%0h", n, log_valid, log_pc, exp_valid, exp_pc);
            end
            checks++; if (log_ovf !== m_ovf)       begin failures++; $display("[TB] FAIL rand_ovf@%0d: got %b expected %b", n, log_ovf, m_ovf); end
        end
    endtask

    initial begin
        m_br = 0; m_miss = 0; m_orphan = 0; m_instr = 0; m_ovf = 1'b0;
        apply_stimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        test_reset();
        test_branches();
        test_log_order();
        test_overflow();
        test_back_to_back();
        test_orphan();
        test_saturation();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/br_stat_collector.md
BR_STAT_COLLECTOR -- requirements
Module: br_stat_collector

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of every statistics counter.
REQ-002 SHALL have parameter LOG_DEPTH, default 8: miss-log FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-005 SHALL have port clear_i, input, 1: synchronous clear of counters, log and overflow flag.
REQ-006 SHALL have port en_i, input, 1: collection enable; when 0, no counter or log update occurs.
REQ-007 SHALL have port br_instr_i, input, 1: a branch/jump is resolving in EX/MEM this cycle.
REQ-008 SHALL have port br_miss_i, input, 1: the predictor mispredicted/flushed this cycle.
REQ-009 SHALL have port instr_i, input, 32: the instruction word in IF this cycle.
REQ-010 SHALL have port pc_i, input, 32: the EX/MEM PC of the resolving branch.
REQ-011 SHALL have ports br_cnt_o, miss_cnt_o, orphan_cnt_o and instr_cnt_o, each output, CNT_WIDTH: the branch, qualified-miss, unqualified-miss and fetched-instruction counts.
REQ-012 SHALL have port log_pc_o, output, 32: the PC at the FIFO head.
REQ-013 SHALL have port log_valid_o, output, 1: the FIFO head is valid.
REQ-014 SHALL have port log_ready_i, input, 1: the consumer accepts the head.
REQ-015 SHALL have port log_ovf_o, output, 1: sticky flag set when a miss was dropped because the log was full.

Function
REQ-016 SHALL increment br_cnt_o by 1 in a cycle with en_i=1 and br_instr_i=1; visible the next cycle.
REQ-017 SHALL increment miss_cnt_o in a cycle with en_i=1, br_instr_i=1 and br_miss_i=1.
REQ-018 SHALL increment orphan_cnt_o in a cycle with en_i=1, br_miss_i=1 and br_instr_i=0; miss_cnt_o is unchanged.
REQ-019 SHALL increment instr_cnt_o in a cycle with en_i=1 and instr_i not equal to 32'h0000_0013 and not equal to 32'h0000_0000 (bubbles are excluded).
REQ-020 SHALL saturate every counter at all-ones; an increment at saturation holds the value, with no wrap.
REQ-021 SHALL push pc_i into the log on every qualified miss (REQ-017); latency from push to log_valid_o=1 is 1 cycle when the FIFO was empty.
REQ-022 SHALL pop the FIFO on a handshake: log_valid_o=1 and log_ready_i=1 in the same cycle.
REQ-023 SHALL drive log_valid_o=0 and log_pc_o=0 when the FIFO is empty; log_ready_i is ignored while empty.
REQ-024 SHALL drop a push that arrives while the FIFO is full with no pop in the same cycle, and set log_ovf_o=1 from the next cycle until clear_i or rst_i.
REQ-025 SHALL, on a simultaneous push and pop while full, perform both; no drop occurs, log_ovf_o is unchanged and the occupancy stays LOG_DEPTH.
REQ-026 SHALL, on a simultaneous push and pop while holding exactly one entry, present the new PC at the head the next cycle with log_valid_o held at 1.
REQ-027 SHALL wrap the read and write pointers modulo LOG_DEPTH and track occupancy with a LOG_DEPTH+1-state count.
REQ-028 SHALL give clear_i priority over any event in the same cycle: the event is not counted and not logged, and all counters, the FIFO and log_ovf_o read 0 the next cycle.
REQ-029 SHALL, when en_i=0, still allow log pops, so draining continues while collection is paused.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, set all counters=0, log_valid_o=0, log_pc_o=0, log_ovf_o=0 and the FIFO pointers and occupancy=0.
REQ-031 SHALL give rst_i priority over clear_i and over all events; a reset mid-drain discards the remaining entries.

Configuration
REQ-032 SHALL, with macro BR_STAT_LOG_EN defined, implement the miss-log FIFO and log_ovf_o per REQ-021..REQ-027.
REQ-033 SHALL, with BR_STAT_LOG_EN undefined, contain no FIFO storage, and tie log_valid_o=0, log_pc_o=0 and log_ovf_o=0; counter behaviour is identical in both builds.

Verification
REQ-034 Bench SHALL cover: after reset, 5 cycles with br_instr_i=1 and br_miss_i=0 -> br_cnt_o=5, miss_cnt_o=0, log_valid_o=0.
REQ-035 Bench SHALL cover: 3 qualified misses at pc_i=0x100, 0x104 and 0x108 with log_ready_i=0 -> miss_cnt_o=3; then log_ready_i=1 -> log_pc_o reads 0x100, 0x104, 0x108 on consecutive cycles, then log_valid_o=0.
REQ-036 Bench SHALL cover: 9 misses with LOG_DEPTH=8 and no pops -> 8 entries held, log_ovf_o=1, miss_cnt_o=9; a 10th miss in the same cycle as a pop is accepted and log_ovf_o stays 1.
REQ-037 Bench SHALL cover: br_miss_i=1 with br_instr_i=0 -> orphan_cnt_o=1, miss_cnt_o=0, nothing logged; instr_i=0x13 -> instr_cnt_o unchanged, instr_i=0x00A00093 -> +1.
REQ-038 Bench SHALL cover: with CNT_WIDTH=4, 20 branches -> br_cnt_o=15 with no wrap; clear_i asserted together with a branch -> br_cnt_o=0 the next cycle.
REQ-039 Bench SHALL cover: rst_i pulsed while 4 entries are queued -> log_valid_o=0 and all counters 0 the next cycle; with BR_STAT_LOG_EN undefined, misses give log_valid_o always 0.
